rs_alu_bank: RTL and testbench
==============================

# rs_alu_bank

Parametrised multi-entry ALU reservation station. It replaces the single-line ALU station with a bank of `DEPTH` entries, each carrying its own tag. The bank snoops the CDB for operands and dispatches the oldest ready entry to the ALU through a valid/ready handshake. Each entry stays allocated until its own result appears on the CDB, so a tag is never reused while its result is still in flight.

## Interface
- `DEPTH`, 4: number of entries, 2..16.
- `TAG_BASE`, 8'h01: tag of entry 0; entry i has tag `TAG_BASE+i`; tag 0 is reserved to mean "operand ready".
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `issue` input 1: allocate an entry this cycle.
- `issue_ready` output 1: at least one entry is FREE.
- `issue_tag` output 8: tag of the entry that `issue` would allocate (lowest-index FREE entry); 0 when full.
- `ALUControl_in` input 4, `q1_in`/`q2_in` input 8, `v1_in`/`v2_in` input 32: operation and operands at issue.
- `cdb` input 41: bit 40 valid, [39:32] tag, [31:0] value.
- `disp_valid` output 1: a READY entry is presented.
- `disp_ready` input 1: ALU accepts the presented entry.
- `disp_ALUControl` output 4, `disp_v1`/`disp_v2` output 32, `disp_tag` output 8: fields of the presented entry.
- `overflow` output 1: sticky; set by `issue` while `issue_ready`=0.

## Operation
- Per-entry state: FREE, WAIT, READY, EXEC.
  - WAIT: an operand tag is non-zero.
  - READY: both tags are 0.
  - EXEC: dispatched; waiting for its own result.
- **Issue** (`issue` && `issue_ready`):
  - Allocates the lowest-index FREE entry and latches `ALUControl_in`, q/v.
  - Same-cycle bypass: if `cdb` is valid and `cdb[39:32]` equals a non-zero `q1_in`/`q2_in`, that operand latches `cdb[31:0]` with q=0.
  - Next state is READY if both resulting q are 0, else WAIT.
- **Issue while full**: ignored; no state change; sets `overflow`.
- **Wakeup**: each WAIT entry compares `cdb` valid+tag against q1 and q2 independently.
  - On a match, it latches the value and clears that q.
  - WAIT→READY when both q are 0 after the update.
- **Age**: the bank keeps a DEPTH×DEPTH age matrix. On allocation of entry i, row i is set to "older than i" for every entry that is non-FREE in that cycle.
- **Select**: the presented entry is the READY entry with no older READY entry.
  - `disp_*` are combinational from registered state only; they do not depend on `cdb` or `issue` in the same cycle.
- **Dispatch** (`disp_valid` && `disp_ready`): the presented entry goes READY→EXEC.
  - While `disp_ready`=0, `disp_*` hold stable unless an older entry becomes READY.
- **Completion**: an EXEC entry whose tag matches a valid `cdb` goes EXEC→FREE.
  - Its own-tag match does not feed wakeup of itself.
- Value width is 32 bits; no arithmetic is done on values, and tags are compared as full 8 bits.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - All entries FREE; age matrix cleared; `overflow`=0.
  - `issue_ready`=1, `issue_tag`=`TAG_BASE`, `disp_valid`=0.
  - `disp_ALUControl`, `disp_v1`, `disp_v2` and `disp_tag` are all 0.
  - Reset mid-operation discards all entries, including EXEC entries.
- **Latency**:
  - Issue with both operands ready → `disp_valid` next cycle (1 cycle).
  - CDB wakeup of the last operand → `disp_valid` next cycle.
- `issue_ready` and `issue_tag` come from registered state. An entry freed by the CDB in cycle N is allocatable from cycle N+1.
- **Simultaneous events in one cycle**:
  - Issue, wakeup of other entries, dispatch and completion may all occur together.
  - Dispatch and allocation never target the same entry.
- With `disp_valid`=0, `disp_*` read 0.

## Test plan
- Reset then issue ALUControl=4'h2, q=0/0, v1=5, v2=7 → `issue_tag`=01; next cycle `disp_valid`=1, `disp_v1`=5, `disp_v2`=7, `disp_tag`=01.
- Issue q1=8'h20, q2=0; three cycles later `cdb`={1,8'h20,32'hDEAD} → the cycle after, `disp_valid`=1 and `disp_v1`=32'hDEAD.
- Same-cycle bypass: issue q2=8'h30 while `cdb`={1,8'h30,32'h55} → entry READY next cycle with `disp_v2`=32'h55.
- Issue A (waits on 8'h20), then B (ready), then broadcast 8'h20 → B dispatched first; after A wakes, A is presented before a later-issued ready C.
- Fill 4 entries → `issue_ready`=0, `issue_tag`=0; a 5th `issue` sets `overflow`=1 with no state change; `cdb` tag 8'h02 on the EXEC entry 1 → `issue_ready`=1 next cycle with `issue_tag`=02.
- Hold `disp_ready`=0 for 5 cycles → `disp_*` stable; assert `rst_n`=0 mid-EXEC → all outputs at reset values immediately.

Source files
------------

// File: rtl/rs_alu_bank_if.sv
// rs_alu_bank_if
//   Bundles the issue, CDB and dispatch signals of the ALU reservation
//   station bank so that the issuing side and the bank share one port.
//
//   Issue side : issue, ALUControl_in, q1_in, q2_in, v1_in, v2_in
//                -> issue_ready, issue_tag, overflow
//   CDB        : cdb[40] valid, cdb[39:32] tag, cdb[31:0] value
//   Dispatch   : disp_valid, disp_ALUControl, disp_v1, disp_v2, disp_tag
//                <- disp_ready
//
//   master : the issuing / ALU / CDB side (drives issue, operands, cdb,
//            disp_ready)
//   slave  : the reservation station bank itself
interface rs_alu_bank_if;

  logic        issue;
  logic        issue_ready;
  logic [7:0]  issue_tag;
  logic [3:0]  ALUControl_in;
  logic [7:0]  q1_in;
  logic [7:0]  q2_in;
  logic [31:0] v1_in;
  logic [31:0] v2_in;

  logic [40:0] cdb;

  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_ALUControl;
  logic [31:0] disp_v1;
  logic [31:0] disp_v2;
  logic [7:0]  disp_tag;

  logic        overflow;

  modport master (
    output issue,
    output ALUControl_in,
    output q1_in,
    output q2_in,
    output v1_in,
    output v2_in,
    output cdb,
    output disp_ready,
    input  issue_ready,
    input  issue_tag,
    input  disp_valid,
    input  disp_ALUControl,
    input  disp_v1,
    input  disp_v2,
    input  disp_tag,
    input  overflow
  );

  modport slave (
    input  issue,
    input  ALUControl_in,
    input  q1_in,
    input  q2_in,
    input  v1_in,
    input  v2_in,
    input  cdb,
    input  disp_ready,
    output issue_ready,
    output issue_tag,
    output disp_valid,
    output disp_ALUControl,
    output disp_v1,
    output disp_v2,
    output disp_tag,
    output overflow
  );

endinterface

// File: rtl/rs_alu_bank.sv
// rs_alu_bank
//   Multi-entry ALU reservation station. Each of the DEPTH entries owns the
//   fixed tag TAG_BASE+i. Entries snoop the CDB for missing operands, the
//   oldest READY entry is presented to the ALU over a valid/ready handshake,
//   and an entry is only released when its own result is seen on the CDB,
//   so a tag can never be handed out twice while its result is in flight.
//
//   Ports:
//     clk   - clock, all state updates on the rising edge
//     rst_n - asynchronous active-low reset
//     bus   - rs_alu_bank_if.slave (issue, CDB snoop and dispatch signals)
//
//   Parameters:
//     DEPTH    - number of entries (2..16)
//     TAG_BASE - tag of entry 0; tag 0 means "operand ready"
module rs_alu_bank #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] TAG_BASE = 8'h01
) (
  input  logic          clk,
  input  logic          rst_n,
  rs_alu_bank_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

  // Registered per-entry state
  logic [1:0]       state   [DEPTH];
  logic [3:0]       alu_q   [DEPTH];
  logic [7:0]       q1_q    [DEPTH];
  logic [7:0]       q2_q    [DEPTH];
  logic [31:0]      v1_q    [DEPTH];
  logic [31:0]      v2_q    [DEPTH];
  // age_q[i][j] = 1 means entry j is older than entry i
  logic [DEPTH-1:0] age_q   [DEPTH];
  logic             overflow_q;

  // Next-state values
  logic [1:0]       state_d [DEPTH];
  logic [3:0]       alu_d   [DEPTH];
  logic [7:0]       q1_d    [DEPTH];
  logic [7:0]       q2_d    [DEPTH];
  logic [31:0]      v1_d    [DEPTH];
  logic [31:0]      v2_d    [DEPTH];
  logic [DEPTH-1:0] age_d   [DEPTH];

  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] busy_vec;

  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  logic             issue_fire;
  logic             disp_fire;

  logic             cdb_valid;
  logic [7:0]       cdb_tag;
  logic [31:0]      cdb_value;

  // Issue-time operands after the same-cycle CDB bypass
  logic [7:0]       q1_byp;
  logic [7:0]       q2_byp;
  logic [31:0]      v1_byp;
  logic [31:0]      v2_byp;

  assign cdb_valid = bus.cdb[40];
  assign cdb_tag   = bus.cdb[39:32];
  assign cdb_value = bus.cdb[31:0];

  // Per-entry status vectors derived purely from registered state
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    busy_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = (state[i] == ST_FREE);
      ready_vec[i] = (state[i] == ST_READY);
      busy_vec[i]  = (state[i] != ST_FREE);
    end
  end

  // Lowest-index FREE entry is the allocation target
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Oldest READY entry: READY with no older READY entry in its age row.
  // The priority scan only matters if the matrix were ever inconsistent.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i] && ((age_q[i] & ready_vec) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_fire = bus.issue && alloc_found;
  assign disp_fire  = sel_found && bus.disp_ready;

  assign bus.issue_ready     = alloc_found;
  assign bus.issue_tag       = alloc_found ? (TAG_BASE + 8'(alloc_idx)) : 8'h00;
  assign bus.overflow        = overflow_q;

  assign bus.disp_valid      = sel_found;
  assign bus.disp_ALUControl = sel_found ? alu_q[sel_idx] : 4'h0;
  assign bus.disp_v1         = sel_found ? v1_q[sel_idx]  : 32'h0;
  assign bus.disp_v2         = sel_found ? v2_q[sel_idx]  : 32'h0;
  assign bus.disp_tag        = sel_found ? (TAG_BASE + 8'(sel_idx)) : 8'h00;

  // Same-cycle bypass: an operand being broadcast right now is captured at
  // issue so it is never missed between issue and the first snoop.
  always_comb begin
    q1_byp = bus.q1_in;
    v1_byp = bus.v1_in;
    q2_byp = bus.q2_in;
    v2_byp = bus.v2_in;
    if (cdb_valid && (bus.q1_in != 8'h00) && (cdb_tag == bus.q1_in)) begin
      q1_byp = 8'h00;
      v1_byp = cdb_value;
    end
    if (cdb_valid && (bus.q2_in != 8'h00) && (cdb_tag == bus.q2_in)) begin
      q2_byp = 8'h00;
      v2_byp = cdb_value;
    end
  end

  // Next-state for every entry: wakeup, dispatch, completion, then the
  // allocation overlays the lowest FREE entry (which none of the other
  // events can touch, since they only act on non-FREE entries).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state[i];
      alu_d[i]   = alu_q[i];
      q1_d[i]    = q1_q[i];
      q2_d[i]    = q2_q[i];
      v1_d[i]    = v1_q[i];
      v2_d[i]    = v2_q[i];
      age_d[i]   = age_q[i];
    end

    for (int i = 0; i < DEPTH; i++) begin
      case (state[i])
        ST_WAIT: begin
          if (cdb_valid && (q1_q[i] != 8'h00) && (cdb_tag == q1_q[i])) begin
            q1_d[i] = 8'h00;
            v1_d[i] = cdb_value;
          end
          if (cdb_valid && (q2_q[i] != 8'h00) && (cdb_tag == q2_q[i])) begin
            q2_d[i] = 8'h00;
            v2_d[i] = cdb_value;
          end
          if ((q1_d[i] == 8'h00) && (q2_d[i] == 8'h00)) begin
            state_d[i] = ST_READY;
          end
        end
        ST_READY: begin
          if (disp_fire && (sel_idx == IDX_W'(i))) begin
            state_d[i] = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cdb_valid && (cdb_tag == (TAG_BASE + 8'(i)))) begin
            state_d[i] = ST_FREE;
          end
        end
        default: begin
        end
      endcase
    end

    if (issue_fire) begin
      alu_d[alloc_idx] = bus.ALUControl_in;
      q1_d[alloc_idx]  = q1_byp;
      q2_d[alloc_idx]  = q2_byp;
      v1_d[alloc_idx]  = v1_byp;
      v2_d[alloc_idx]  = v2_byp;
      if ((q1_byp == 8'h00) && (q2_byp == 8'h00)) begin
        state_d[alloc_idx] = ST_READY;
      end else begin
        state_d[alloc_idx] = ST_WAIT;
      end
      // The new entry is younger than everything currently held; its
      // column is cleared so stale bits from a previous occupant of this
      // slot never make it look older than entries still in the bank.
      for (int k = 0; k < DEPTH; k++) begin
        age_d[k][alloc_idx] = 1'b0;
      end
      age_d[alloc_idx] = busy_vec;
    end
  end

  // Entry storage and age matrix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= ST_FREE;
        alu_q[i] <= 4'h0;
        q1_q[i]  <= 8'h00;
        q2_q[i]  <= 8'h00;
        v1_q[i]  <= 32'h0;
        v2_q[i]  <= 32'h0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state[i] <= state_d[i];
        alu_q[i] <= alu_d[i];
        q1_q[i]  <= q1_d[i];
        q2_q[i]  <= q2_d[i];
        v1_q[i]  <= v1_d[i];
        v2_q[i]  <= v2_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  // Sticky flag for an issue attempt made while the bank was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.issue && !alloc_found) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_alu_bank.sv
// tb_rs_alu_bank
//   Directed, table-driven bench for rs_alu_bank (DEPTH=4, TAG_BASE=8'h01).
//   Each table row is one clock cycle: inputs are driven just after the
//   falling edge and the registered outputs are compared 1 time unit later,
//   i.e. they reflect all rising edges of the preceding rows. A short
//   hand-written sequence at the end covers asynchronous reset mid-EXEC.
module tb_rs_alu_bank;

  logic clk;
  logic rst_n;

  rs_alu_bank_if bus ();

  rs_alu_bank #(
    .DEPTH    (4),
    .TAG_BASE (8'h01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        issue;
    logic [3:0]  alu;
    logic [7:0]  q1;
    logic [7:0]  q2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        cv;
    logic [7:0]  ctag;
    logic [31:0] cval;
    logic        dr;
    logic        e_rdy;
    logic [7:0]  e_itag;
    logic        e_dv;
    logic [3:0]  e_alu;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [7:0]  e_dtag;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(
    input logic iss, input logic [3:0] alu, input logic [7:0] q1, input logic [7:0] q2,
    input logic [31:0] v1, input logic [31:0] v2,
    input logic cv, input logic [7:0] ctag, input logic [31:0] cval, input logic dr,
    input logic rdy, input logic [7:0] itag, input logic dv, input logic [3:0] dalu,
    input logic [31:0] dv1, input logic [31:0] dv2, input logic [7:0] dtag, input logic ovf);
    vec_t r;
    r.issue = iss;  r.alu = alu;   r.q1 = q1;     r.q2 = q2;
    r.v1 = v1;      r.v2 = v2;     r.cv = cv;     r.ctag = ctag;
    r.cval = cval;  r.dr = dr;     r.e_rdy = rdy; r.e_itag = itag;
    r.e_dv = dv;    r.e_alu = dalu; r.e_v1 = dv1; r.e_v2 = dv2;
    r.e_dtag = dtag; r.e_ovf = ovf;
    return r;
  endfunction

  task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.issue         = v.issue;
    bus.ALUControl_in = v.alu;
    bus.q1_in         = v.q1;
    bus.q2_in         = v.q2;
    bus.v1_in         = v.v1;
    bus.v2_in         = v.v2;
    bus.cdb           = {v.cv, v.ctag, v.cval};
    bus.disp_ready    = v.dr;
  endtask

  task automatic checkOutput(input vec_t v, input string label);
    #1;
    compareField({label, "/issue_ready"}, 32'(bus.issue_ready),     32'(v.e_rdy));
    compareField({label, "/issue_tag"},   32'(bus.issue_tag),       32'(v.e_itag));
    compareField({label, "/disp_valid"},  32'(bus.disp_valid),      32'(v.e_dv));
    compareField({label, "/disp_alu"},    32'(bus.disp_ALUControl), 32'(v.e_alu));
    compareField({label, "/disp_v1"},     bus.disp_v1,              v.e_v1);
    compareField({label, "/disp_v2"},     bus.disp_v2,              v.e_v2);
    compareField({label, "/disp_tag"},    32'(bus.disp_tag),        32'(v.e_dtag));
    compareField({label, "/overflow"},    32'(bus.overflow),        32'(v.e_ovf));
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle   = mk(0,4'h0,8'h00,8'h00,32'h0,32'h0, 0,8'h00,32'h0, 0, 1,8'h01, 0,4'h0,32'h0,32'h0,8'h00, 0);
    applyStimulus(idle);

    //           iss alu  q1     q2     v1          v2        cv ctag  cval        dr rdy itag  dv alu  dv1         dv2       dtag  ovf
    // Basic issue with ready operands and dispatch/complete
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r0 reset
    vecs.push_back(mk(1,4'h2,8'h00,8'h00,32'h5,     32'h7,    0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r1
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 1,4'h2,32'h5,     32'h7,    8'h01, 0)); // r2
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h02, 1,4'h2,32'h5,     32'h7,    8'h01, 0)); // r3
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h01,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r4
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r5
    // CDB wakeup of q1 three cycles after issue
    vecs.push_back(mk(1,4'h3,8'h20,8'h00,32'h0,     32'h9,    0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r6
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r7
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r8
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h20,32'hDEAD,   0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r9
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h02, 1,4'h3,32'hDEAD,  32'h9,    8'h01, 0)); // r10
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h01,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r11
    // Same-cycle bypass on q2
    vecs.push_back(mk(1,4'h4,8'h00,8'h30,32'h11,    32'h0,    1,8'h30,32'h55,     0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r12
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h02, 1,4'h4,32'h11,    32'h55,   8'h01, 0)); // r13
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h01,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r14
    // Age ordering: A waits, B ready, C issued after A wakes
    vecs.push_back(mk(1,4'h5,8'h20,8'h00,32'h0,     32'h1,    0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r15 A
    vecs.push_back(mk(1,4'h6,8'h00,8'h00,32'h2,     32'h3,    0,8'h00,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r16 B
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h20,32'hAA,     1, 1,8'h03, 1,4'h6,32'h2,     32'h3,    8'h02, 0)); // r17
    vecs.push_back(mk(1,4'h7,8'h00,8'h00,32'h8,     32'h9,    0,8'h00,32'h0,      0, 1,8'h03, 1,4'h5,32'hAA,    32'h1,    8'h01, 0)); // r18 C
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h04, 1,4'h5,32'hAA,    32'h1,    8'h01, 0)); // r19
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h04, 1,4'h7,32'h8,     32'h9,    8'h03, 0)); // r20
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h01,32'h0,      0, 1,8'h04, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r21
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h02,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r22
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h03,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r23
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r24
    // Fill the bank, overflow, free entry 1 through its own tag
    vecs.push_back(mk(1,4'h1,8'h00,8'h00,32'h10,    32'h20,   0,8'h00,32'h0,      0, 1,8'h01, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r25
    vecs.push_back(mk(1,4'h1,8'h00,8'h00,32'h11,    32'h21,   0,8'h00,32'h0,      1, 1,8'h02, 1,4'h1,32'h10,    32'h20,   8'h01, 0)); // r26
    vecs.push_back(mk(1,4'h1,8'h40,8'h00,32'h0,     32'h22,   0,8'h00,32'h0,      1, 1,8'h03, 1,4'h1,32'h11,    32'h21,   8'h02, 0)); // r27
    vecs.push_back(mk(1,4'h1,8'h41,8'h00,32'h0,     32'h23,   0,8'h00,32'h0,      0, 1,8'h04, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r28
    vecs.push_back(mk(1,4'hF,8'h00,8'h00,32'h99,    32'h99,   0,8'h00,32'h0,      0, 0,8'h00, 0,4'h0,32'h0,     32'h0,    8'h00, 0)); // r29 5th
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h02,32'h0,      0, 0,8'h00, 0,4'h0,32'h0,     32'h0,    8'h00, 1)); // r30
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 1)); // r31
    // Hold disp_ready low; a younger entry waking must not disturb disp_*
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h40,32'h77,     0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 1)); // r32
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 1,4'h1,32'h77,    32'h22,   8'h03, 1)); // r33
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    1,8'h41,32'h88,     0, 1,8'h02, 1,4'h1,32'h77,    32'h22,   8'h03, 1)); // r34
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 1,4'h1,32'h77,    32'h22,   8'h03, 1)); // r35
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 1,4'h1,32'h77,    32'h22,   8'h03, 1)); // r36
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      0, 1,8'h02, 1,4'h1,32'h77,    32'h22,   8'h03, 1)); // r37
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h02, 1,4'h1,32'h77,    32'h22,   8'h03, 1)); // r38
    vecs.push_back(mk(0,4'h0,8'h00,8'h00,32'h0,     32'h0,    0,8'h00,32'h0,      1, 1,8'h02, 1,4'h1,32'h88,    32'h23,   8'h04, 1)); // r39
    vecs.push_back(mk(1,4'h9,8'h00,8'h00,32'h1,     32'h2,    0,8'h00,32'h0,      0, 1,8'h02, 0,4'h0,32'h0,     32'h0,    8'h00, 1)); // r40

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("row%0d", i));
    end

    // Hand-written: entries 0, 2, 3 in EXEC, entry 1 READY, bank full.
    applyStimulus(idle);
    checkOutput(mk(0,4'h0,8'h00,8'h00,32'h0,32'h0, 0,8'h00,32'h0, 0,
                   0,8'h00, 1,4'h9,32'h1,32'h2,8'h02, 1), "pre_reset");

    // Asynchronous reset in the middle of the cycle, away from any edge.
    #2;
    rst_n = 1'b0;
    checkOutput(idle, "async_reset");

    // Release reset and confirm the bank stays empty after a clock edge.
    applyStimulus(idle);
    rst_n = 1'b1;
    applyStimulus(idle);
    checkOutput(idle, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
